// File: rtl/data_memory_unit.sv
// data_memory_unit: word-organised data RAM for the MIPS MEM stage.
// Serves byte/halfword/word loads and stores at BASE_ADDR with sign/zero
// extension, reports misaligned or out-of-range accesses through
// resp_error, and optionally zeroes every word with a sweep after reset.
//
// Handshake: a request is accepted on a rising clock edge where
// req_valid && req_ready. req_ready depends only on registered state (never
// on req_valid). Each accepted request produces exactly one resp_valid pulse,
// with resp_read_data/resp_error valid in that same cycle, in the cycle after
// edge (accept + LATENCY - 1). A request pending when clear_n falls is
// dropped without response or memory write.
module data_memory_unit #(
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 1,
  parameter bit          INIT_CLEAR  = 1'b1
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_address,
  input  logic [31:0] req_write_data,
  output logic        resp_valid,
  output logic [31:0] resp_read_data,
  output logic        resp_error,
  output logic        init_busy,
  output logic [1:0]  state_dbg
);

  localparam int          IW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH_WORDS - 1);
  localparam logic [1:0]  CNT_INIT  = 2'(LATENCY - 1);
  // With LATENCY=1 the accepting edge is also the response edge, so the
  // access is decoded straight from the request inputs.
  localparam bit          DIRECT    = (LATENCY == 1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  localparam state_t RESET_STATE = INIT_CLEAR ? ST_INIT : ST_IDLE;

  state_t        state_q, state_d;
  logic          ready_q, ready_d;
  logic [IW-1:0] sweep_idx_q, sweep_idx_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          op_write_q, op_write_d;
  logic [1:0]    op_size_q, op_size_d;
  logic          op_signed_q, op_signed_d;
  logic [31:0]   op_addr_q, op_addr_d;
  logic [31:0]   op_data_q, op_data_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_data_q, resp_data_d;
  logic          resp_error_q, resp_error_d;

  logic [31:0]   mem_q [DEPTH_WORDS];

  // Access currently being resolved (live request or latched one).
  logic          accept;
  logic          fire;
  logic          cur_write;
  logic [1:0]    cur_size;
  logic          cur_signed;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_data;

  logic [32:0]   offset;
  logic          acc_err;
  logic [IW-1:0] acc_idx;
  logic [1:0]    lane;
  logic [31:0]   rd_word;
  logic [3:0]    byte_en;
  logic [31:0]   wr_lanes;
  logic [31:0]   merged_word;
  logic [31:0]   load_value;

  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [31:0]   wr_word;

  assign req_ready      = ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_read_data = resp_data_q;
  assign resp_error     = resp_error_q;
  assign init_busy      = (state_q == ST_INIT);
  assign state_dbg      = state_q;

  assign accept = req_valid && ready_q;

  // Select which access is resolved this cycle and when it completes.
  always_comb begin
    if (DIRECT) begin
      fire       = accept;
      cur_write  = req_write;
      cur_size   = req_size;
      cur_signed = req_signed;
      cur_addr   = req_address;
      cur_data   = req_write_data;
    end else begin
      fire       = (state_q == ST_BUSY) && (cnt_q == 2'd1);
      cur_write  = op_write_q;
      cur_size   = op_size_q;
      cur_signed = op_signed_q;
      cur_addr   = op_addr_q;
      cur_data   = op_data_q;
    end
  end

  // Decode the access: error checks, lane enables, merged store word, load value.
  always_comb begin
    offset   = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
    acc_err  = offset[32] || (offset >= MEM_BYTES) || (cur_size == 2'b11) ||
               ((cur_size == 2'b01) && cur_addr[0]) ||
               ((cur_size == 2'b10) && (cur_addr[1:0] != 2'b00));
    acc_idx  = offset[IW+1:2];
    lane     = cur_addr[1:0];
    rd_word  = mem_q[acc_idx];

    byte_en    = 4'b0000;
    wr_lanes   = cur_data;
    load_value = 32'd0;
    case (cur_size)
      2'b00: begin
        byte_en    = 4'b0001 << lane;
        wr_lanes   = {4{cur_data[7:0]}};
        load_value = {24'd0, rd_word[{lane, 3'b000} +: 8]};
        if (cur_signed && load_value[7]) load_value[31:8] = 24'hFFFFFF;
      end
      2'b01: begin
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
        wr_lanes   = {2{cur_data[15:0]}};
        load_value = {16'd0, rd_word[{lane[1], 4'b0000} +: 16]};
        if (cur_signed && load_value[15]) load_value[31:16] = 16'hFFFF;
      end
      2'b10: begin
        byte_en    = 4'b1111;
        wr_lanes   = cur_data;
        load_value = rd_word;
      end
      default: begin
        byte_en    = 4'b0000;
        wr_lanes   = cur_data;
        load_value = 32'd0;
      end
    endcase

    for (int i = 0; i < 4; i++) begin
      merged_word[8*i +: 8] = byte_en[i] ? wr_lanes[8*i +: 8] : rd_word[8*i +: 8];
    end
  end

  // Memory write port: the clear sweep has priority over accesses (they never
  // overlap because req_ready is low during the sweep).
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = acc_idx;
    wr_word = merged_word;
    if ((state_q == ST_INIT) && clear_n) begin
      wr_en   = 1'b1;
      wr_idx  = sweep_idx_q;
      wr_word = 32'd0;
    end else if (fire && cur_write && !acc_err) begin
      wr_en   = 1'b1;
    end
  end

  // Next-state, handshake and response logic.
  always_comb begin
    state_d      = state_q;
    sweep_idx_d  = sweep_idx_q;
    cnt_d        = cnt_q;
    op_write_d   = op_write_q;
    op_size_d    = op_size_q;
    op_signed_d  = op_signed_q;
    op_addr_d    = op_addr_q;
    op_data_d    = op_data_q;

    case (state_q)
      ST_INIT: begin
        sweep_idx_d = sweep_idx_q + 1'b1;
        if (sweep_idx_q == LAST_IDX) begin
          sweep_idx_d = '0;
          state_d     = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          op_write_d  = req_write;
          op_size_d   = req_size;
          op_signed_d = req_signed;
          op_addr_d   = req_address;
          op_data_d   = req_write_data;
          if (!DIRECT) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 2'd1) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d      = (state_d == ST_IDLE);
    resp_valid_d = fire;
    resp_error_d = fire && acc_err;
    resp_data_d  = (fire && !acc_err && !cur_write) ? load_value : 32'd0;
  end

  // Control and response registers; reset drops any pending access.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q      <= RESET_STATE;
      ready_q      <= 1'b0;
      sweep_idx_q  <= '0;
      cnt_q        <= 2'd0;
      op_write_q   <= 1'b0;
      op_size_q    <= 2'b00;
      op_signed_q  <= 1'b0;
      op_addr_q    <= 32'd0;
      op_data_q    <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      sweep_idx_q  <= sweep_idx_d;
      cnt_q        <= cnt_d;
      op_write_q   <= op_write_d;
      op_size_q    <= op_size_d;
      op_signed_q  <= op_signed_d;
      op_addr_q    <= op_addr_d;
      op_data_q    <= op_data_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
    end
  end

  // Storage array: not reset, so contents survive reset when INIT_CLEAR=0.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_idx] <= wr_word;
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// Bench for data_memory_unit: unit 0 (LATENCY=1, INIT_CLEAR=1, 256 words)
// and unit 1 (LATENCY=3, INIT_CLEAR=0, 16 words) share one clock.
// Expected responses come from a byte-addressed reference model.
module tb_data_memory_unit;

  localparam logic [31:0] BASE = 32'h10010000;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        clear_n0, req_valid0, req_ready0, req_write0, req_signed0;
  logic [1:0]  req_size0, state_dbg0;
  logic [31:0] req_address0, req_write_data0, resp_read_data0;
  logic        resp_valid0, resp_error0, init_busy0;

  logic        clear_n1, req_valid1, req_ready1, req_write1, req_signed1;
  logic [1:0]  req_size1, state_dbg1;
  logic [31:0] req_address1, req_write_data1, resp_read_data1;
  logic        resp_valid1, resp_error1, init_busy1;

  data_memory_unit #(.BASE_ADDR(BASE), .DEPTH_WORDS(256), .LATENCY(1), .INIT_CLEAR(1'b1)) u0 (
    .clock(clock), .clear_n(clear_n0), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(req_write0), .req_size(req_size0), .req_signed(req_signed0),
    .req_address(req_address0), .req_write_data(req_write_data0),
    .resp_valid(resp_valid0), .resp_read_data(resp_read_data0), .resp_error(resp_error0),
    .init_busy(init_busy0), .state_dbg(state_dbg0));

  data_memory_unit #(.BASE_ADDR(BASE), .DEPTH_WORDS(16), .LATENCY(3), .INIT_CLEAR(1'b0)) u1 (
    .clock(clock), .clear_n(clear_n1), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write1), .req_size(req_size1), .req_signed(req_signed1),
    .req_address(req_address1), .req_write_data(req_write_data1),
    .resp_valid(resp_valid1), .resp_read_data(resp_read_data1), .resp_error(resp_error1),
    .init_busy(init_busy1), .state_dbg(state_dbg1));

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  logic [7:0]  mdl0[1024];
  logic [7:0]  mdl1[64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: byte-addressed little-endian memory, {error, data}.
  function automatic logic [32:0] model(input int u, input bit wr, input logic [1:0] sz,
                                        input bit sg, input logic [31:0] a, input logic [31:0] wd);
    longint off;
    int depth;
    int nb;
    logic [31:0] v;
    depth = (u == 0) ? 256 : 16;
    off = longint'(a) - longint'(BASE);
    if (off < 0 || off >= 4 * depth || sz == 2'b11 ||
        (sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0))
      return {1'b1, 32'd0};
    nb = 1 << sz;
    v = 32'd0;
    for (int i = 0; i < nb; i++) begin
      if (wr) begin
        if (u == 0) mdl0[int'(off) + i] = wd[8*i +: 8];
        else        mdl1[int'(off) + i] = wd[8*i +: 8];
      end else begin
        v[8*i +: 8] = (u == 0) ? mdl0[int'(off) + i] : mdl1[int'(off) + i];
      end
    end
    if (wr) return 33'd0;
    if (sg && nb == 1 && v[7])  v[31:8]  = 24'hFFFFFF;
    if (sg && nb == 2 && v[15]) v[31:16] = 16'hFFFF;
    return {1'b0, v};
  endfunction

  function automatic logic rdy(input int u);
    return (u == 0) ? req_ready0 : req_ready1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input int u, input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd, input bit expect_resp);
    int n;
    @(negedge clock);
    if (u == 0) begin
      req_write0 = wr; req_size0 = sz; req_signed0 = sg;
      req_address0 = a; req_write_data0 = wd; req_valid0 = 1'b1;
    end else begin
      req_write1 = wr; req_size1 = sz; req_signed1 = sg;
      req_address1 = a; req_write_data1 = wd; req_valid1 = 1'b1;
    end
    n = 0;
    while (!rdy(u) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout unit=%0d actual=not_ready required=ready", u);
      if (u == 0) req_valid0 = 1'b0; else req_valid1 = 1'b0;
      return;
    end
    if (expect_resp) begin
      if (u == 0) exp_q0.push_back(model(u, wr, sz, sg, a, wd));
      else        exp_q1.push_back(model(u, wr, sz, sg, a, wd));
    end
    @(posedge clock);
    #1;
    if (u == 0) req_valid0 = 1'b0; else req_valid1 = 1'b0;
  endtask

  task automatic drain(input int u);
    int n;
    n = 0;
    while (((u == 0) ? exp_q0.size() : exp_q1.size()) > 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk($sformatf("drain%0d", u), (u == 0) ? exp_q0.size() : exp_q1.size(), 0);
  endtask

  // Release unit 0 and measure the clear sweep; a request held during the
  // sweep must be ignored.
  task automatic sweep_check();
    int n;
    int bad;
    @(negedge clock);
    clear_n0 = 1'b1;
    req_write0 = 1'b1; req_size0 = 2'b10; req_signed0 = 1'b0;
    req_address0 = BASE; req_write_data0 = 32'hFFFFFFFF; req_valid0 = 1'b1;
    n = 0;
    bad = 0;
    while (init_busy0 && n < 1000) begin
      n++;
      if (req_ready0 !== 1'b0) bad++;
      @(negedge clock);
    end
    req_valid0 = 1'b0;
    chk("sweep_len", n, 256);
    chk("ready_during_sweep", bad, 0);
    chk("ready_after_sweep", req_ready0, 1'b1);
    for (int i = 0; i < 1024; i++) mdl0[i] = 8'h00;
  endtask

  task automatic reset_outputs_check(input int u, input logic busy_req);
    if (u == 0) begin
      chk("rst0_ready", req_ready0, 1'b0);
      chk("rst0_valid", resp_valid0, 1'b0);
      chk("rst0_data", resp_read_data0, 32'd0);
      chk("rst0_error", resp_error0, 1'b0);
      chk("rst0_busy", init_busy0, busy_req);
    end else begin
      chk("rst1_ready", req_ready1, 1'b0);
      chk("rst1_valid", resp_valid1, 1'b0);
      chk("rst1_data", resp_read_data1, 32'd0);
      chk("rst1_error", resp_error1, 1'b0);
      chk("rst1_busy", init_busy1, busy_req);
    end
  endtask

  // Response timing for the LATENCY=3 unit, called right after an accept edge.
  task automatic lat3_check();
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      chk("lat3_wait_valid", resp_valid1, 1'b0);
      chk("lat3_wait_ready", req_ready1, 1'b0);
    end
    @(negedge clock);
    chk("lat3_resp_valid", resp_valid1, 1'b1);
    chk("lat3_resp_ready", req_ready1, 1'b1);
    @(negedge clock);
    chk("lat3_pulse_end", resp_valid1, 1'b0);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clock) begin
    if (resp_valid0 === 1'b1) begin
      if (exp_q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp0 actual=resp required=none at %0t", $time);
      end else begin
        chk("resp0", {31'd0, resp_error0, resp_read_data0}, {31'd0, exp_q0.pop_front()});
      end
    end
  end

  always @(negedge clock) begin
    if (resp_valid1 === 1'b1) begin
      if (exp_q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp1 actual=resp required=none at %0t", $time);
      end else begin
        chk("resp1", {31'd0, resp_error1, resp_read_data1}, {31'd0, exp_q1.pop_front()});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    clear_n0 = 1'b0; req_valid0 = 1'b0; req_write0 = 1'b0; req_size0 = 2'b00;
    req_signed0 = 1'b0; req_address0 = 32'd0; req_write_data0 = 32'd0;
    clear_n1 = 1'b0; req_valid1 = 1'b0; req_write1 = 1'b0; req_size1 = 2'b00;
    req_signed1 = 1'b0; req_address1 = 32'd0; req_write_data1 = 32'd0;
    for (int i = 0; i < 64; i++) mdl1[i] = 8'hxx;
    repeat (3) @(negedge clock);
    reset_outputs_check(0, 1'b1);
    reset_outputs_check(1, 1'b0);

    // First sweep, then plant junk and reset again.
    sweep_check();
    issue(0, 1'b0, 2'b10, 1'b0, BASE, 32'd0, 1'b1);
    issue(0, 1'b1, 2'b10, 1'b0, BASE, 32'h12345678, 1'b1);
    issue(0, 1'b1, 2'b10, 1'b0, BASE + 32'h3FC, 32'hA5A5A5A5, 1'b1);
    issue(0, 1'b0, 2'b10, 1'b0, BASE, 32'd0, 1'b1);
    drain(0);
    @(negedge clock);
    clear_n0 = 1'b0;
    repeat (2) @(negedge clock);
    reset_outputs_check(0, 1'b1);
    sweep_check();
    issue(0, 1'b0, 2'b10, 1'b0, BASE, 32'd0, 1'b1);
    issue(0, 1'b0, 2'b10, 1'b0, BASE + 32'h3FC, 32'd0, 1'b1);

    // Directed loads/stores on word 1.
    issue(0, 1'b1, 2'b10, 1'b0, BASE + 4, 32'hDEADBEEF, 1'b1);
    @(negedge clock);
    chk("lat1_resp_valid", resp_valid0, 1'b1);
    issue(0, 1'b0, 2'b10, 1'b0, BASE + 4, 32'd0, 1'b1);
    issue(0, 1'b0, 2'b00, 1'b1, BASE + 7, 32'd0, 1'b1);
    issue(0, 1'b0, 2'b00, 1'b0, BASE + 7, 32'd0, 1'b1);
    issue(0, 1'b0, 2'b01, 1'b1, BASE + 4, 32'd0, 1'b1);
    issue(0, 1'b0, 2'b01, 1'b0, BASE + 6, 32'd0, 1'b1);
    issue(0, 1'b1, 2'b00, 1'b0, BASE + 5, 32'h0000AB12, 1'b1);
    issue(0, 1'b0, 2'b10, 1'b0, BASE + 4, 32'd0, 1'b1);
    issue(0, 1'b1, 2'b01, 1'b0, BASE + 6, 32'h00005555, 1'b1);
    issue(0, 1'b0, 2'b10, 1'b0, BASE + 4, 32'd0, 1'b1);
    // Error cases.
    issue(0, 1'b0, 2'b10, 1'b0, 32'h1000FFFC, 32'd0, 1'b1);
    issue(0, 1'b1, 2'b10, 1'b0, 32'h10010400, 32'hFFFFFFFF, 1'b1);
    issue(0, 1'b0, 2'b01, 1'b1, 32'h10010001, 32'd0, 1'b1);
    issue(0, 1'b1, 2'b10, 1'b0, 32'h10010006, 32'hFFFFFFFF, 1'b1);
    issue(0, 1'b1, 2'b11, 1'b0, BASE + 4, 32'hFFFFFFFF, 1'b1);
    issue(0, 1'b0, 2'b11, 1'b0, BASE + 4, 32'd0, 1'b1);
    issue(0, 1'b0, 2'b10, 1'b0, BASE + 4, 32'd0, 1'b1);
    drain(0);

    // Randomised traffic on unit 0, back-to-back with random gaps.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clock);
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0: a = BASE - 32'($urandom_range(1, 16));
        1: a = BASE + 32'h400 + 32'($urandom_range(0, 15));
        default: a = BASE + 32'($urandom_range(0, 1023));
      endcase
      if ($urandom_range(0, 4) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
      issue(0, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom(), 1'b1);
    end
    drain(0);

    // Unit 1: release, fill, LATENCY=3 timing, random, reset during BUSY.
    @(negedge clock);
    clear_n1 = 1'b1;
    chk("u1_ready_at_release", req_ready1, 1'b0);
    @(negedge clock);
    chk("u1_ready_after_release", req_ready1, 1'b1);
    for (int w = 0; w < 16; w++) issue(1, 1'b1, 2'b10, 1'b0, BASE + 32'(4 * w), $urandom(), 1'b1);
    drain(1);
    issue(1, 1'b1, 2'b10, 1'b0, BASE + 4, 32'hCAFEF00D, 1'b1);
    lat3_check();
    issue(1, 1'b0, 2'b10, 1'b0, BASE + 4, 32'd0, 1'b1);
    lat3_check();
    for (int k = 0; k < 60; k++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a = ($urandom_range(0, 7) == 0) ? BASE + 32'h40 + 32'($urandom_range(0, 7))
                                      : BASE + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 4) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
      issue(1, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom(), 1'b1);
    end
    drain(1);
    issue(1, 1'b1, 2'b10, 1'b0, BASE + 8, 32'h00000001, 1'b1);
    drain(1);
    issue(1, 1'b1, 2'b10, 1'b0, BASE + 8, 32'h00000002, 1'b0);
    @(negedge clock);
    clear_n1 = 1'b0;
    #1;
    reset_outputs_check(1, 1'b0);
    @(negedge clock);
    clear_n1 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk("dropped_no_resp", resp_valid1, 1'b0);
    end
    issue(1, 1'b0, 2'b10, 1'b0, BASE + 8, 32'd0, 1'b1);
    drain(1);

    // ---------------- final report ----------------
    chk("final_q0_empty", exp_q0.size(), 0);
    chk("final_q1_empty", exp_q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory_unit.md
# data_memory_unit

Parametrised successor to the single-cycle data memory for the MIPS datapath. It is a word-organised RAM mapped at a configurable base address and serves byte, halfword and word loads/stores with sign/zero extension. It uses a valid/ready request and registered response handshake with configurable latency, flags misaligned and out-of-range accesses instead of silently ignoring them, and clears its contents with a sequential sweep after reset. It sits between the multicycle/pipelined datapath's MEM stage and the rest of the core.

## Interface
- BASE_ADDR, 32'h10010000: byte address of word 0.
- DEPTH_WORDS, 256: number of 32-bit words. Must be a power of two and at least 2. Index width is IW = $clog2(DEPTH_WORDS).
- LATENCY, 1: cycles from the accepting edge to the response edge. Legal range is 1..4.
- INIT_CLEAR, 1: when 1, all words are zeroed after reset. When 0, contents are retained across reset.

Ports:
- clock  in  1  single clock, all state on posedge.
- clear_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on an edge where req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1 sign-extends, 0 zero-extends.
- req_address  in  32  byte address.
- req_write_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle response pulse, issued for loads and stores.
- resp_read_data  out  32  load result; 0 for stores and errors.
- resp_error  out  1  valid with resp_valid: access rejected.
- init_busy  out  1  clear sweep in progress.

## Operation
- States:
  - INIT: zero sweep.
  - IDLE: ready.
  - BUSY: waiting LATENCY-1 cycles.
- After clear_n rises:
  - INIT_CLEAR=1: enter INIT and write 0 to index 0..DEPTH_WORDS-1, one word per cycle. Then go to IDLE.
  - INIT_CLEAR=0: go directly to IDLE.
- req_ready = (state==IDLE). It is combinational from the state register only, never from req_valid.
- On accept, latch write, size, signed, address and data.
  - LATENCY=1: stay in IDLE.
  - Otherwise: enter BUSY with counter = LATENCY-1, decrement each cycle, return to IDLE on the edge that raises resp_valid.
- Error check (any condition sets resp_error):
  - Range uses a 33-bit offset = {1'b0,address} - {1'b0,BASE_ADDR}. Error if the offset is negative or >= 4*DEPTH_WORDS.
  - Error if req_size==11.
  - Error if a halfword has address[0]=1.
  - Error if a word has address[1:0]!=0.
  - On error: no memory write, resp_read_data=0.
- Byte lanes are little-endian. Lane n = bits [8n+7:8n] and is selected by address[1:0]. Index = offset[IW+1:2].
- Stores:
  - sb writes lane address[1:0] with data[7:0].
  - sh writes lanes {a1,0} and {a1,1} with data[15:0].
  - sw writes all lanes.
  - Other lanes are unchanged.
- Loads extract the lane(s), then sign- or zero-extend to 32 bits per the latched signed bit. Word loads ignore signed.
- The memory write is committed, and read data is sampled, on the response edge. A load accepted after a store to the same word returns the new data.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_read_data=0, resp_error=0.
  - init_busy=INIT_CLEAR during reset and until the sweep ends.
  - state=INIT if INIT_CLEAR=1, otherwise IDLE.
  - req_ready rises one cycle after clear_n deasserts (INIT_CLEAR=0), or one cycle after the last sweep write (INIT_CLEAR=1).
- Accepting edge E: resp_valid, resp_read_data and resp_error are registered and high for exactly the cycle after edge E+LATENCY-1.
  - LATENCY=1 gives the response in the cycle after E.
  - Peak throughput is one access per LATENCY cycles. LATENCY=1 allows back-to-back accepts.
- The sweep takes exactly DEPTH_WORDS cycles.
  - init_busy falls on the same edge as the final write.
  - req_ready is low throughout the sweep.
  - req_valid during INIT is ignored and has no effect.
- clear_n low at any time:
  - All outputs go immediately to their reset values.
  - A pending request is dropped: no response, no write.
  - An in-progress sweep restarts from index 0.
- Write enable is never asserted while clear_n is low.

## Test plan
- Reset with INIT_CLEAR=1, DEPTH_WORDS=256, pre-fill a word with junk → init_busy high for 256 cycles, req_ready=0 throughout; afterwards lw 0x10010000 → 0x00000000, error 0.
- sw 0x10010004=0xDEADBEEF → resp_valid with data 0. Then:
  - lw 0x10010004 → 0xDEADBEEF.
  - lb 0x10010007 → 0xFFFFFFDE, lbu → 0x000000DE.
  - lh 0x10010004 → 0xFFFFBEEF, lhu 0x10010006 → 0x0000DEAD.
- sb 0x10010005 data 0xAB12 → lw 0x10010004 returns 0xDEAD12EF; sh 0x10010006 data 0x5555 → 0x555512EF.
- Errors, all giving resp_error=1 and data 0, with 0x10010004 still 0x555512EF afterwards:
  - lw 0x1000FFFC
  - sw 0x10010400
  - lh 0x10010001
  - sw 0x10010006
  - req_size=11
- LATENCY=3, sw then lw to the same word:
  - Accept at edge 0 → resp_valid only in the cycle after edge 2, req_ready low in between.
  - The lw returns the stored value.
- INIT_CLEAR=0, write 0x1 to 0x10010008, issue sw 0x2 with LATENCY=3, pulse clear_n low in the BUSY cycle → no resp_valid; after reset lw returns 0x00000001.
